// File: rtl/bitblaster_pkg.sv
// Shared types and constants for the 10-bit processor controller.
//   class_e : instruction class encodings (INST top two bits)
//   op_e    : register-op opcodes 0000-1011
//   state_e : controller timesteps; encoding doubles as the T display value
//   kind_e  : decoded instruction kind used to pick the step sequence
//   ALU_ADD / ALU_SUB : ALU codes used by the immediate classes
package bitblaster_pkg;

   typedef enum logic [1:0] {
      CL_REG  = 2'b00,
      CL_ILL  = 2'b01,
      CL_ADDI = 2'b10,
      CL_SUBI = 2'b11
   } class_e;

   typedef enum logic [3:0] {
      OP_LD   = 4'b0000,
      OP_CP   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_INV  = 4'b0100,
      OP_FLP  = 4'b0101,
      OP_BIN6 = 4'b0110,
      OP_BIN7 = 4'b0111,
      OP_BIN8 = 4'b1000,
      OP_BIN9 = 4'b1001,
      OP_BINA = 4'b1010,
      OP_BINB = 4'b1011
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      K_LD,
      K_CP,
      K_ALU2,
      K_ALU1,
      K_IMM,
      K_ILL
   } kind_e;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction field extractor and classifier.
//   inst : instruction register contents
//   rx   : destination / first source register field
//   ry   : second source register field
//   imm  : zero-extended immediate field (overlaps ry and op)
//   kind : step-sequence class (ld, cp, binary, unary, immediate, illegal)
//   alu  : ALU operation for the T2 step (0 for non-ALU kinds)
module inst_decode
   import bitblaster_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int REG_AW = 2
) (
   input  logic [DATA_W-1:0] inst,
   output logic [REG_AW-1:0] rx,
   output logic [REG_AW-1:0] ry,
   output logic [DATA_W-1:0] imm,
   output kind_e             kind,
   output logic [3:0]        alu
);

   localparam int IMM_W = DATA_W - 2 - REG_AW;

   logic [1:0] cls;
   logic [3:0] op;

   assign cls = inst[DATA_W-1 -: 2];
   assign rx  = inst[DATA_W-3 -: REG_AW];
   assign ry  = inst[DATA_W-3-REG_AW -: REG_AW];
   assign op  = inst[3:0];
   assign imm = {{(DATA_W-IMM_W){1'b0}}, inst[IMM_W-1:0]};

   always_comb begin
      kind = K_ILL;
      alu  = 4'b0000;
      case (cls)
         CL_REG: begin
            case (op)
               OP_LD: kind = K_LD;
               OP_CP: kind = K_CP;
               OP_INV, OP_FLP: begin
                  kind = K_ALU1;
                  alu  = op;
               end
               OP_ADD, OP_SUB, OP_BIN6, OP_BIN7,
               OP_BIN8, OP_BIN9, OP_BINA, OP_BINB: begin
                  kind = K_ALU2;
                  alu  = op;
               end
               default: kind = K_ILL;   // 1100-1111 unassigned
            endcase
         end
         CL_ADDI: begin
            kind = K_IMM;
            alu  = ALU_ADD;
         end
         CL_SUBI: begin
            kind = K_IMM;
            alu  = ALU_SUB;
         end
         default: kind = K_ILL;
      endcase
   end

endmodule

// File: rtl/seq_controller.sv
// Clocked processor controller: fetch (IDLE with exec) then up to three
// execute steps T1..T3, driving register-file, ALU, bus-source and IR load.
//   clk, rst          : clock, synchronous active-high reset
//   exec              : start request, honoured only in IDLE
//   INST              : instruction register, held stable while busy
//   IMM               : zero-extended immediate (bus gate is Iout)
//   Iout/Ext/Gout/ENR : bus sources, mutually exclusive
//   Rin/ENW, Rout     : register-file write / read address and enables
//   Ain, Gin, ALUcont : ALU input/output loads and operation
//   IRin              : load instruction register (fetch)
//   Clr/done          : last step of the instruction
//   busy, err, T      : in-progress, illegal-instruction pulse, timestep
module seq_controller
   import bitblaster_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int NREG   = 4,
   parameter int REG_AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exec,
   input  logic [DATA_W-1:0] INST,
   output logic [DATA_W-1:0] IMM,
   output logic              Iout,
   output logic [REG_AW-1:0] Rin,
   output logic [REG_AW-1:0] Rout,
   output logic              ENW,
   output logic              ENR,
   output logic              Ain,
   output logic              Gin,
   output logic              Gout,
   output logic [3:0]        ALUcont,
   output logic              Ext,
   output logic              IRin,
   output logic              Clr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        T
);

   state_e            state;
   kind_e             kind;
   logic [REG_AW-1:0] rx, ry;
   logic [DATA_W-1:0] imm;
   logic [3:0]        alu;

   inst_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
      .inst (INST),
      .rx   (rx),
      .ry   (ry),
      .imm  (imm),
      .kind (kind),
      .alu  (alu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (exec) state <= S_T1;
            // ld, cp and illegal complete in T1
            S_T1:   state <= (kind == K_LD || kind == K_CP || kind == K_ILL) ? S_IDLE : S_T2;
            S_T2:   state <= S_T3;
            S_T3:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Reset overrides every output so an abandoned instruction can never
   // write the register file in the reset cycle.
   always_comb begin
      Iout    = 1'b0;
      Rin     = '0;
      Rout    = '0;
      ENW     = 1'b0;
      ENR     = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      ALUcont = 4'b0000;
      Ext     = 1'b0;
      IRin    = 1'b0;
      Clr     = 1'b0;
      err     = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE: IRin = exec;
            S_T1: begin
               case (kind)
                  K_LD: begin
                     Ext = 1'b1;
                     ENW = 1'b1;
                     Rin = rx;
                     Clr = 1'b1;
                  end
                  K_CP: begin
                     ENR  = 1'b1;
                     Rout = ry;
                     ENW  = 1'b1;
                     Rin  = rx;
                     Clr  = 1'b1;
                  end
                  K_ILL: begin
                     err = 1'b1;
                     Clr = 1'b1;
                  end
                  K_ALU1: begin
                     ENR  = 1'b1;
                     Rout = ry;
                     Ain  = 1'b1;
                  end
                  default: begin   // binary ops and immediates read Rx first
                     ENR  = 1'b1;
                     Rout = rx;
                     Ain  = 1'b1;
                  end
               endcase
            end
            S_T2: begin
               ALUcont = alu;
               Gin     = 1'b1;
               if (kind == K_IMM) begin
                  Iout = 1'b1;
               end else begin
                  ENR  = 1'b1;
                  Rout = ry;
               end
            end
            S_T3: begin
               Gout = 1'b1;
               ENW  = 1'b1;
               Rin  = rx;
               Clr  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign IMM  = rst ? '0 : imm;
   assign T    = rst ? 2'd0 : state;
   assign busy = !rst && (state != S_IDLE);
   assign done = Clr;

   // At most one bus driver per cycle.
   a_bus_excl: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ENR, Ext, Gout, Iout}));

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised, clocked successor to the combinational processor controller. Owns the timestep counter internally and sequences every instruction through fetch and up to three execute steps, driving the register-file, ALU, bus-source and instruction-register control signals. Adds an exec/busy/done handshake, an illegal-instruction flag, and width/register-count generalisation. Sits between the instruction register and the datapath of the 10-bit processor.

## Interface
- `DATA_W`, 10: data and instruction width; must satisfy `DATA_W >= 6 + 2*REG_AW`.
- `NREG`, 4: register-file entries; power of two, at least 2.
- `REG_AW`, `$clog2(NREG)`: register address width (derived).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `exec` input 1: start request, sampled only in IDLE.
- `INST` input DATA_W: instruction register contents, stable from T1 until done.
- `IMM` output DATA_W: zero-extended immediate.
- `Iout` output 1: drive the bus from IMM.
- `Rin` output REG_AW: write address.
- `Rout` output REG_AW: read address.
- `ENW` output 1: register-file write enable.
- `ENR` output 1: register-file read enable.
- `Ain` output 1: load ALU input A.
- `Gin` output 1: load ALU output G.
- `Gout` output 1: drive the bus from G.
- `ALUcont` output 4: ALU operation.
- `Ext` output 1: drive the bus from external data.
- `IRin` output 1: load the instruction register.
- `Clr` output 1: final step of the instruction.
- `busy` output 1: instruction in progress.
- `done` output 1: one-cycle completion pulse, equal to Clr.
- `err` output 1: one-cycle pulse on an illegal instruction.
- `T` output 2: current timestep, for display.

## Operation
- Instruction fields:
  - class = `INST[DATA_W-1:DATA_W-2]`
  - Rx = `INST[DATA_W-3 -: REG_AW]`
  - Ry = next REG_AW bits below Rx
  - op = `INST[3:0]`
  - imm = `INST[DATA_W-3-REG_AW:0]`, zero-extended into IMM
- IMM is always driven. Iout gates whether it reaches the bus.
- Instruction classes:
  - 00 is register ops.
  - 10 is addi; ALUcont = 0010.
  - 11 is subi; ALUcont = 0011.
  - 01, and class 00 with op 1100–1111, are illegal.
- States: IDLE, T1, T2, T3. T output is 0, 1, 2, 3 respectively.
- IDLE:
  - `IRin = exec`.
  - If exec, go to T1.
- ld (op 0000):
  - T1: Ext, ENW, Rin=Rx, Clr. Return to IDLE.
- cp (op 0001):
  - T1: ENR, Rout=Ry, ENW, Rin=Rx, Clr. Return to IDLE.
- Binary ALU ops (0010, 0011, 0110–1011):
  - T1: ENR, Rout=Rx, Ain.
  - T2: ENR, Rout=Ry, ALUcont=op, Gin.
  - T3: Gout, ENW, Rin=Rx, Clr.
- Unary ops inv (0100) and flp (0101):
  - Same as binary, except Rout=Ry in T1.
- addi / subi:
  - T1: ENR, Rout=Rx, Ain.
  - T2: Iout, ALUcont per class, Gin.
  - T3: Gout, ENW, Rin=Rx, Clr.
- Illegal instruction:
  - T1: err and Clr. No ENW, Ext, Gout or Iout. Return to IDLE.
- Signals not listed for a step are 0. Rin, Rout and ALUcont are 0 when unused.
- Bus exclusivity: at most one of ENR (bus read), Ext, Gout, Iout is asserted per cycle. This is a checked invariant.

## Timing
- State is registered. Outputs are combinational from state and INST (IDLE also uses exec).
- While rst is 1, all outputs are forced to 0. On the next clock edge the state becomes IDLE.
- Reset mid-instruction abandons it: no ENW on or after the reset cycle.
- Latency counted from the exec cycle (IRin) to Clr:
  - ld, cp, illegal: 1 cycle.
  - All ALU ops and immediates: 3 cycles.
- `busy` = (state ≠ IDLE).
- exec while busy is ignored. exec in the Clr cycle is ignored; a new fetch needs exec in IDLE.
- Back-to-back throughput with exec held high: one instruction per 2 (short) or 4 (long) cycles.
- INST changing while busy is a protocol violation; the bench asserts against it.

## Structure
- `bitblaster_pkg` holds:
  - `class_e` (class encodings)
  - `op_e` (opcodes 0000–1011)
  - `state_e` (IDLE, T1, T2, T3)
  - ALU code constants: ALU_ADD = 0010, ALU_SUB = 0011
- One sub-module: `inst_decode`, a combinational field extractor and classifier. Outputs rx, ry, imm, kind (ld / cp / alu2 / alu1 / imm / illegal) and alu code.

## Test plan
- Reset, then exec with `INST = 00_01_10_0010` (add R1,R2) and defaults → IRin at cycle 0. T1: Rout=1, Ain. T2: Rout=2, ALUcont=0010, Gin. T3: Gout, ENW, Rin=1, Clr, done. busy high for 3 cycles.
- `INST = 00_11_00_0000` (ld R3) → one cycle after IRin: Ext, ENW, Rin=3, Clr. ENR=0.
- `INST = 11_10_101010` (subi R2,42) → IMM = 0x02A. T2: Iout, ALUcont=0011. T3: Rin=2, ENW.
- `INST = 01_00_000000`, then `00_00_00_1111` → err pulse and Clr at T1, never ENW; back in IDLE next cycle.
- exec held high throughout an add → second IRin appears only after Clr, in IDLE; no IRin while busy.
- rst asserted in T2 of a sub → next cycle IDLE, all outputs 0, no ENW. A subsequent exec restarts cleanly.
